// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared types and default address windows for mem_responder
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_FETCH = 2'd0,
      OP_LOAD  = 2'd1,
      OP_STORE = 2'd2
   } op_t;

   localparam logic [31:0] C_INSTR_BASE  = 32'h0000_0000;
   localparam logic [31:0] C_INSTR_LIMIT = 32'h0000_0FFC;
   localparam logic [31:0] C_DATA_BASE   = 32'h0000_1000;
   localparam logic [31:0] C_DATA_LIMIT  = 32'h0000_1FFC;

endpackage

`default_nettype wire

// File: rtl/addr_checker.sv
// ============================================================================
// addr_checker : word alignment plus unsigned [base, limit] window check
// Rev 1.0
// ============================================================================
`default_nettype none

module addr_checker (
   input  logic [31:0] i_addr,
   input  logic [31:0] i_base,
   input  logic [31:0] i_limit,
   output logic        o_legal
);

   assign o_legal = (i_addr[1:0] == 2'b00) && (i_addr >= i_base) && (i_addr <= i_limit);

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : checks fetch / load / store requests against their windows
//                 and serialises legal ones onto a single-port sync memory
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 1,
   parameter logic [31:0] INSTR_BASE  = C_INSTR_BASE,
   parameter logic [31:0] INSTR_LIMIT = C_INSTR_LIMIT,
   parameter logic [31:0] DATA_BASE   = C_DATA_BASE,
   parameter logic [31:0] DATA_LIMIT  = C_DATA_LIMIT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch,
   input  logic [31:0] pc_addr,
   input  logic        ld,
   input  logic        st,
   input  logic [31:0] data_addr,
   input  logic [31:0] st_data,
   output logic [31:0] instruction,
   output logic [31:0] ld_data,
   output logic        wait_instr,
   output logic        wait_data,
   output logic        instr_segv,
   output logic        data_segv,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   localparam logic [2:0] c_LAT = 3'(MEM_LATENCY);

   state_t      r_state;
   op_t         r_op;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_cnt;
   logic [31:0] r_instruction;
   logic [31:0] r_ld_data;

   state_t      w_state_nxt;
   op_t         w_op_nxt;
   logic [2:0]  w_cnt_nxt;
   logic        w_latch;
   logic        w_cap_instr;
   logic        w_cap_ld;
   logic        w_instr_ok;
   logic        w_data_ok;
   logic        w_data_req;

   addr_checker u_instr_chk (
      .i_addr  (pc_addr),
      .i_base  (INSTR_BASE),
      .i_limit (INSTR_LIMIT),
      .o_legal (w_instr_ok)
   );

   addr_checker u_data_chk (
      .i_addr  (data_addr),
      .i_base  (DATA_BASE),
      .i_limit (DATA_LIMIT),
      .o_legal (w_data_ok)
   );

   assign w_data_req = ld | st;

   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_cap_instr = 1'b0;
      w_cap_ld    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Data requests win over a simultaneous fetch.
            if (w_data_req) begin
               w_op_nxt = st ? OP_STORE : OP_LOAD;
               if (w_data_ok && !(ld && st)) begin
                  w_state_nxt = ST_ACCESS;
                  w_latch     = 1'b1;
                  w_cnt_nxt   = st ? 3'd1 : c_LAT;
               end else begin
                  w_state_nxt = ST_FAULT;
               end
            end else if (fetch) begin
               w_op_nxt = OP_FETCH;
               if (w_instr_ok) begin
                  w_state_nxt = ST_ACCESS;
                  w_latch     = 1'b1;
                  w_cnt_nxt   = c_LAT;
               end else begin
                  w_state_nxt = ST_FAULT;
               end
            end
         end
         ST_ACCESS: begin
            if (r_cnt == 3'd1) begin
               w_state_nxt = ST_DONE;
               w_cap_instr = (r_op == OP_FETCH);
               w_cap_ld    = (r_op == OP_LOAD);
            end else begin
               w_cnt_nxt = r_cnt - 3'd1;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         ST_FAULT: begin
            if ((r_op == OP_FETCH) ? !fetch : !w_data_req)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_op          <= OP_FETCH;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_cnt         <= '0;
         r_instruction <= '0;
         r_ld_data     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_op    <= w_op_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_latch) begin
            r_addr  <= w_data_req ? data_addr : pc_addr;
            r_wdata <= st_data;
         end
         if (w_cap_instr) r_instruction <= mem_rdata;
         if (w_cap_ld)    r_ld_data     <= mem_rdata;
      end
   end

   assign instruction = r_instruction;
   assign ld_data     = r_ld_data;

   assign mem_re    = (r_state == ST_ACCESS) && (r_op != OP_STORE);
   assign mem_we    = (r_state == ST_ACCESS) && (r_op == OP_STORE);
   assign mem_addr  = (r_state == ST_ACCESS) ? r_addr : '0;
   assign mem_wdata = mem_we ? r_wdata : '0;

   assign instr_segv = (r_state == ST_FAULT) && (r_op == OP_FETCH);
   assign data_segv  = (r_state == ST_FAULT) && (r_op != OP_FETCH);

   assign wait_data  = w_data_req
                     & ~((r_state == ST_DONE)  && (r_op != OP_FETCH))
                     & ~((r_state == ST_FAULT) && (r_op != OP_FETCH));
   assign wait_instr = fetch
                     & ~((r_state == ST_DONE)  && (r_op == OP_FETCH))
                     & ~((r_state == ST_FAULT) && (r_op == OP_FETCH));

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder : directed checks of mem_responder at latency 1 and 3
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset;

   // latency-1 instance, backed by a small word memory
   logic        fetch, ld, st;
   logic [31:0] pc_addr, data_addr, st_data;
   logic [31:0] instruction, ld_data, mem_addr, mem_wdata, mem_rdata;
   logic        wait_instr, wait_data, instr_segv, data_segv, mem_re, mem_we;

   // latency-3 instance, read data driven directly
   logic        fetch_3, ld_3, st_3;
   logic [31:0] pc_addr_3, data_addr_3, st_data_3;
   logic [31:0] instruction_3, ld_data_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
   logic        wait_instr_3, wait_data_3, instr_segv_3, data_segv_3, mem_re_3, mem_we_3;

   logic [31:0] mem [0:4095];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[13:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[13:2]] <= mem_wdata;

   mem_responder #(.MEM_LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset), .fetch(fetch), .pc_addr(pc_addr), .ld(ld), .st(st),
      .data_addr(data_addr), .st_data(st_data), .instruction(instruction), .ld_data(ld_data),
      .wait_instr(wait_instr), .wait_data(wait_data), .instr_segv(instr_segv),
      .data_segv(data_segv), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
      .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   mem_responder #(.MEM_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset), .fetch(fetch_3), .pc_addr(pc_addr_3), .ld(ld_3), .st(st_3),
      .data_addr(data_addr_3), .st_data(st_data_3), .instruction(instruction_3),
      .ld_data(ld_data_3), .wait_instr(wait_instr_3), .wait_data(wait_data_3),
      .instr_segv(instr_segv_3), .data_segv(data_segv_3), .mem_addr(mem_addr_3),
      .mem_wdata(mem_wdata_3), .mem_re(mem_re_3), .mem_we(mem_we_3), .mem_rdata(mem_rdata_3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic data_fault(input string tag, input logic [31:0] addr, input logic l, input logic s);
      ld = l; st = s; data_addr = addr;
      tick();
      check({tag, "_segv"}, data_segv, 1);
      check({tag, "_isegv"}, instr_segv, 0);
      check({tag, "_re"}, mem_re, 0);
      check({tag, "_we"}, mem_we, 0);
      check({tag, "_wait"}, wait_data, 0);
      tick();
      check({tag, "_hold"}, data_segv, 1);
      ld = 0; st = 0;
      tick();
      check({tag, "_clr"}, data_segv, 0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem[12'h004] = 32'hC0DE_0001;
      mem[12'h008] = 32'hC0DE_0020;
      mem[12'h402] = 32'hDA7A_0008;
      mem[12'h7FF] = 32'h1FFC_BEEF;
      mem[12'h3FF] = 32'h0FFC_0FFC;
      reset = 1; fetch = 0; ld = 0; st = 0; pc_addr = 0; data_addr = 0; st_data = 0;
      fetch_3 = 0; ld_3 = 0; st_3 = 0; pc_addr_3 = 0; data_addr_3 = 0; st_data_3 = 0;
      mem_rdata_3 = 32'h3333_0003;
      tick(); tick();
      reset = 0;
      tick();
      check("rst_instr", instruction, 0);
      check("rst_ld", ld_data, 0);
      check("rst_waits", {wait_instr, wait_data, instr_segv, data_segv}, 0);
      check("rst_mem", {mem_re, mem_we}, 0);
      check("rst_maddr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);

      // single fetch, latency 1
      fetch = 1; pc_addr = 32'h10;
      #1 check("f_wait_idle", wait_instr, 1);
      tick();
      check("f_re", mem_re, 1);
      check("f_addr", mem_addr, 32'h10);
      check("f_wait_acc", wait_instr, 1);
      tick();
      check("f_instr", instruction, 32'hC0DE_0001);
      check("f_wait_done", wait_instr, 0);
      check("f_re_done", mem_re, 0);
      fetch = 0;
      tick();

      // store then load back
      st = 1; data_addr = 32'h1004; st_data = 32'hA5A5_A5A5;
      tick();
      check("s_we", mem_we, 1);
      check("s_re", mem_re, 0);
      check("s_addr", mem_addr, 32'h1004);
      check("s_wdata", mem_wdata, 32'hA5A5_A5A5);
      check("s_wait", wait_data, 1);
      tick();
      check("s_we_done", mem_we, 0);
      check("s_wait_done", wait_data, 0);
      st = 0;
      tick();
      ld = 1;
      tick();
      check("l_re", mem_re, 1);
      check("l_addr", mem_addr, 32'h1004);
      tick();
      check("l_data", ld_data, 32'hA5A5_A5A5);
      check("l_wait_done", wait_data, 0);
      check("l_instr_hold", instruction, 32'hC0DE_0001);
      ld = 0;
      tick();

      // load and fetch together: load first
      fetch = 1; pc_addr = 32'h20; ld = 1; data_addr = 32'h1008;
      tick();
      check("p_addr_ld", mem_addr, 32'h1008);
      check("p_wi_acc", wait_instr, 1);
      tick();
      check("p_ld", ld_data, 32'hDA7A_0008);
      check("p_wd_done", wait_data, 0);
      check("p_wi_done", wait_instr, 1);
      ld = 0;
      tick();
      check("p_idle_re", mem_re, 0);
      check("p_idle_wi", wait_instr, 1);
      tick();
      check("p_addr_f", mem_addr, 32'h20);
      check("p_re_f", mem_re, 1);
      tick();
      check("p_instr", instruction, 32'hC0DE_0020);
      check("p_wi_end", wait_instr, 0);
      check("p_ld_hold", ld_data, 32'hDA7A_0008);
      fetch = 0;
      tick();

      // illegal data accesses
      data_fault("mis", 32'h1002, 1, 0);
      data_fault("oor", 32'h2000, 1, 0);
      data_fault("below", 32'h0FFC, 1, 0);
      data_fault("ldst", 32'h1000, 1, 1);

      // upper data boundary is legal
      ld = 1; data_addr = 32'h1FFC;
      tick();
      check("bd_re", mem_re, 1);
      tick();
      check("bd_ld", ld_data, 32'h1FFC_BEEF);
      ld = 0;
      tick();

      // upper instruction boundary legal, data window illegal for fetch
      fetch = 1; pc_addr = 32'h0FFC;
      tick(); tick();
      check("bi_instr", instruction, 32'h0FFC_0FFC);
      fetch = 0;
      tick();
      fetch = 1; pc_addr = 32'h1000;
      tick();
      check("if_segv", instr_segv, 1);
      check("if_dsegv", data_segv, 0);
      check("if_wait", wait_instr, 0);
      check("if_mem", {mem_re, mem_we}, 0);
      fetch = 0;
      tick();
      check("if_clr", instr_segv, 0);
      tick();

      // latency 3 load
      ld_3 = 1; data_addr_3 = 32'h1014;
      tick();
      check("l3_re1", mem_re_3, 1);
      tick();
      check("l3_re2", mem_re_3, 1);
      tick();
      check("l3_re3", mem_re_3, 1);
      check("l3_ld_pend", ld_data_3, 0);
      check("l3_wait", wait_data_3, 1);
      tick();
      check("l3_ld", ld_data_3, 32'h3333_0003);
      check("l3_re_done", mem_re_3, 0);
      check("l3_wait_done", wait_data_3, 0);
      ld_3 = 0;
      tick();

      // reset during the second ACCESS cycle
      mem_rdata_3 = 32'h3333_0004; ld_3 = 1; data_addr_3 = 32'h1018;
      tick();
      tick();
      check("r3_re", mem_re_3, 1);
      reset = 1; ld_3 = 0;
      tick();
      check("r3_ld", ld_data_3, 0);
      check("r3_mem", {mem_re_3, mem_we_3}, 0);
      check("r3_addr", mem_addr_3, 0);
      check("r3_flags", {wait_instr_3, wait_data_3, instr_segv_3, data_segv_3}, 0);
      reset = 0;
      tick();
      check("r3_idle_re", mem_re_3, 0);
      tick();
      check("r3_idle_ld", ld_data_3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
